// File: rtl/stream_mux_pkg.sv
// Shared encodings for the N:1 stream multiplexer: lock FSM states and arbitration modes.
package stream_mux_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

endpackage

// File: rtl/stream_mux_nx1_rr_arbiter.sv
// Round-robin priority search: first requester at or after ptr_i, wrapping from NUM_CH-1 to 0.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [IDX_W-1:0]  gnt_idx_o
);

  // Walk the distance from ptr downward so the nearest requester is written last and wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      int j;
      j = int'(ptr_i) + i;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (req_i[j]) begin
        gnt_o     = '0;
        gnt_o[j]  = 1'b1;
        gnt_idx_o = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/stream_mux_nx1.sv
// N:1 stream mux with one output register; explicit-select or round-robin arbitration.
// Define STREAM_MUX_LOCK_EN to hold the grant on one channel until its in_last beat.
module stream_mux_nx1
  import stream_mux_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int NUM_CH    = 4,
  parameter int SEL_W     = $clog2(NUM_CH)
) (
  input  logic                        Clk,
  input  logic                        Rst_n,
  input  logic [NUM_CH*DATAWIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]           in_valid,
  input  logic [NUM_CH-1:0]           in_last,
  output logic [NUM_CH-1:0]           in_ready,
  input  logic                        mode,
  input  logic [SEL_W-1:0]            sel,
  output logic [DATAWIDTH-1:0]        out_data,
  output logic                        out_valid,
  output logic                        out_last,
  output logic [SEL_W-1:0]            out_ch,
  input  logic                        out_ready
);

  logic [DATAWIDTH-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic [SEL_W-1:0]     ch_q, ch_d;
  logic [SEL_W-1:0]     rr_ptr_q, rr_ptr_d;

  logic [NUM_CH-1:0]    rr_gnt, sel_oh, gnt_vec;
  logic [SEL_W-1:0]     rr_idx, gnt_ch;
  logic [DATAWIDTH-1:0] beat_data;
  logic                 beat_last;
  logic                 may_load, xfer;

`ifdef STREAM_MUX_LOCK_EN
  lock_state_e          lock_q;
  logic [SEL_W-1:0]     lock_ch_q;
  logic [NUM_CH-1:0]    lock_oh;
`endif

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (SEL_W)
  ) u_rr_arb (
    .req_i     (in_valid),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (rr_gnt),
    .gnt_idx_o (rr_idx)
  );

  // sel beyond NUM_CH-1 matches no bit, so nothing is granted.
  always_comb begin
    sel_oh = '0;
    for (int k = 0; k < NUM_CH; k++) sel_oh[k] = (sel == SEL_W'(k));
    if (mode == MODE_RR) begin
      gnt_vec = rr_gnt;
      gnt_ch  = rr_idx;
    end else begin
      gnt_vec = sel_oh;
      gnt_ch  = sel;
    end
`ifdef STREAM_MUX_LOCK_EN
    lock_oh = '0;
    for (int k = 0; k < NUM_CH; k++) lock_oh[k] = (lock_ch_q == SEL_W'(k));
    if (lock_q == LOCKED) begin
      gnt_vec = lock_oh;
      gnt_ch  = lock_ch_q;
    end
`endif
  end

  // out_ready only gates the load enable; it never feeds the arbitration itself.
  assign may_load = ~valid_q | out_ready;
  assign in_ready = gnt_vec & {NUM_CH{may_load & Rst_n}};
  assign xfer     = |(in_ready & in_valid);

  always_comb begin
    beat_data = '0;
    beat_last = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (in_ready[k]) begin
        beat_data = in_data[k*DATAWIDTH +: DATAWIDTH];
        beat_last = in_last[k];
      end
    end
  end

  always_comb begin
    valid_d  = xfer ? 1'b1 : (out_ready ? 1'b0 : valid_q);
    data_d   = xfer ? beat_data : data_q;
    last_d   = xfer ? beat_last : last_q;
    ch_d     = xfer ? gnt_ch : ch_q;
    rr_ptr_d = rr_ptr_q;
    if (xfer) rr_ptr_d = (gnt_ch == SEL_W'(NUM_CH - 1)) ? '0 : gnt_ch + 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      last_q   <= 1'b0;
      ch_q     <= '0;
      rr_ptr_q <= '0;
    end else begin
      valid_q  <= valid_d;
      data_q   <= data_d;
      last_q   <= last_d;
      ch_q     <= ch_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef STREAM_MUX_LOCK_EN
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      lock_q    <= IDLE;
      lock_ch_q <= '0;
    end else begin
      case (lock_q)
        IDLE: if (xfer && !beat_last) begin
          lock_q    <= LOCKED;
          lock_ch_q <= gnt_ch;
        end
        LOCKED: if (xfer && beat_last) lock_q <= IDLE;
        default: lock_q <= IDLE;
      endcase
    end
  end
`endif

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign out_ch    = ch_q;

endmodule
